// File: rtl/window_tile_fetcher_pkg.sv
// window_pkg: shared types, default geometry and the map address builder
// for the window trigger / tile-map address generator.
//
// Contents:
//   win_state_e    - fetcher ownership state (IDLE, START, ACTIVE)
//   DEF_*          - default parameter values for window_tile_fetcher
//   build_map_addr - packs {base, sel, row, col} into one address word
package window_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACTIVE = 2'd2
  } win_state_e;

  localparam int unsigned DEF_NUM_WIN   = 1;
  localparam int unsigned DEF_X_W       = 8;
  localparam int unsigned DEF_Y_W       = 8;
  localparam int unsigned DEF_COL_W     = 5;
  localparam int unsigned DEF_ROW_W     = 5;
  localparam int unsigned DEF_TILE_LOG2 = 3;
  localparam int unsigned DEF_ADDR_W    = 13;
  localparam logic [1:0]  DEF_BASE_HI   = 2'b11;

  // The result is 32 bits wide; callers truncate to their own address
  // width. Fields are assumed already masked to row_w / col_w bits.
  function automatic logic [31:0] build_map_addr(
    input logic [31:0] base,
    input logic        sel,
    input logic [31:0] row,
    input logic [31:0] col,
    input int unsigned row_w,
    input int unsigned col_w
  );
    logic [31:0] addr;
    addr = (base << (row_w + col_w + 1))
         | (32'(sel) << (row_w + col_w))
         | (row << col_w)
         | col;
    return addr;
  endfunction

endpackage

// File: rtl/window_tile_fetcher_channel.sv
// window_channel: per-window state for the window tile fetcher.
//
// Tracks whether the window's start row has been reached this frame
// (y_hit), whether the window owned the fetcher during the current line
// (used), and the window-relative line counter.
//
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   frame_start   - clears all channel state
//   line_start    - advances line_cnt if used, then clears used
//   en            - window enable
//   h, v          - current pixel X / line
//   x, y          - window start position
//   set_used      - this channel won the trigger this cycle
//   match         - enabled, start row reached and h == x
//   line_cnt      - window-relative line counter
module window_channel
  import window_pkg::*;
#(
  parameter int unsigned X_W = DEF_X_W,
  parameter int unsigned Y_W = DEF_Y_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_start,
  input  logic           line_start,
  input  logic           en,
  input  logic [X_W-1:0] h,
  input  logic [Y_W-1:0] v,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           set_used,
  output logic           match,
  output logic [Y_W-1:0] line_cnt
);

  logic y_hit;
  logic used;

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      y_hit    <= 1'b0;
      used     <= 1'b0;
      line_cnt <= '0;
    end else begin
      if (en && (v == y)) begin
        y_hit <= 1'b1;
      end
      // A trigger never coincides with line_start (the top drops it), so
      // the set_used branch only matters mid-line.
      if (line_start) begin
        if (used) begin
          line_cnt <= line_cnt + 1'b1;
        end
        used <= 1'b0;
      end else if (set_used) begin
        used <= 1'b1;
      end
    end
  end

  always_comb begin
    match = en && y_hit && (h == x);
  end

endmodule

// File: rtl/window_tile_fetcher.sv
// window_tile_fetcher: window trigger and tile-map address generator.
//
// NUM_WIN window channels with fixed priority (index 0 highest). When the
// fetcher is idle and a window's start row has been reached, the window
// whose X position equals the pixel counter takes ownership; the fetcher
// then receives the tile-map address for that window until the line ends.
//
// Ports:
//   clk2, reset_video2 - video clock, synchronous active-high reset
//   frame_start        - vblank pulse, clears all window state
//   line_start         - start-of-line pulse, ends window ownership
//   h, v               - current pixel X / line
//   win_en/x/y/map_sel - per-window enable, start position, map select
//   fetch_req          - map entry consumed, advance the column
//   win_start          - one-cycle pulse when a window takes ownership
//   win_active         - a window owns the fetcher
//   win_id             - index of the owning window
//   map_addr           - {BASE_HI, map_sel[id], row, col}
//   fine_y             - line within the current tile row
module window_tile_fetcher
  import window_pkg::*;
#(
  parameter int unsigned NUM_WIN   = DEF_NUM_WIN,
  parameter int unsigned X_W       = DEF_X_W,
  parameter int unsigned Y_W       = DEF_Y_W,
  parameter int unsigned COL_W     = DEF_COL_W,
  parameter int unsigned ROW_W     = DEF_ROW_W,
  parameter int unsigned TILE_LOG2 = DEF_TILE_LOG2,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-COL_W-ROW_W-2:0] BASE_HI = DEF_BASE_HI,
  localparam int unsigned WID_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic                   clk2,
  input  logic                   reset_video2,
  input  logic                   frame_start,
  input  logic                   line_start,
  input  logic [X_W-1:0]         h,
  input  logic [Y_W-1:0]         v,
  input  logic [NUM_WIN-1:0]     win_en,
  input  logic [NUM_WIN*X_W-1:0] win_x,
  input  logic [NUM_WIN*Y_W-1:0] win_y,
  input  logic [NUM_WIN-1:0]     map_sel,
  input  logic                   fetch_req,
  output logic                   win_start,
  output logic                   win_active,
  output logic [WID_W-1:0]       win_id,
  output logic [ADDR_W-1:0]      map_addr,
  output logic [TILE_LOG2-1:0]   fine_y
);

  localparam int unsigned BASE_W = ADDR_W - 1 - ROW_W - COL_W;
  localparam logic [ADDR_W-1:0] RESET_ADDR =
    {BASE_HI, {(ADDR_W - BASE_W){1'b0}}};

  logic [NUM_WIN-1:0] match;
  logic [NUM_WIN-1:0] grant;
  logic [Y_W-1:0]     line_cnt [NUM_WIN];

  win_state_e     state, state_n;
  logic [COL_W-1:0] col, col_n;
  logic [WID_W-1:0] id_n;
  logic [WID_W-1:0] winner;
  logic             any_match;
  logic             trigger;
  logic             cur_en;
  logic             sel_n;
  logic [Y_W-1:0]   cnt_n;
  logic [ROW_W-1:0] row_n;
  logic [ADDR_W-1:0] addr_n;

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_ch
    window_channel #(
      .X_W (X_W),
      .Y_W (Y_W)
    ) u_ch (
      .clk         (clk2),
      .reset       (reset_video2),
      .frame_start (frame_start),
      .line_start  (line_start),
      .en          (win_en[i]),
      .h           (h),
      .v           (v),
      .x           (win_x[i*X_W +: X_W]),
      .y           (win_y[i*Y_W +: Y_W]),
      .set_used    (grant[i]),
      .match       (match[i]),
      .line_cnt    (line_cnt[i])
    );
  end

  // Scan from the top index down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    winner    = '0;
    any_match = 1'b0;
    for (int unsigned i = NUM_WIN; i > 0; i--) begin
      if (match[i-1]) begin
        winner    = WID_W'(i - 1);
        any_match = 1'b1;
      end
    end
  end

  always_comb begin
    cur_en = 1'b0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      if (win_id == WID_W'(i)) begin
        cur_en = win_en[i];
      end
    end
  end

  // Next-state, column and ownership; event priority is frame_start,
  // line_start, abort, trigger, fetch_req.
  always_comb begin
    state_n    = state;
    col_n      = col;
    id_n       = win_id;
    trigger    = 1'b0;
    win_start  = (state == START);
    win_active = (state != IDLE);
    if (frame_start) begin
      state_n = IDLE;
      col_n   = '0;
    end else if (line_start) begin
      state_n = IDLE;
    end else if ((state != IDLE) && !cur_en) begin
      state_n = IDLE;
      col_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_match) begin
            trigger = 1'b1;
            state_n = START;
            col_n   = '0;
            id_n    = winner;
          end
        end
        START: begin
          state_n = ACTIVE;
          if (fetch_req) begin
            col_n = col + 1'b1;
          end
        end
        ACTIVE: begin
          if (fetch_req) begin
            col_n = col + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // line_cnt only changes on line_start/frame_start, both of which force
  // IDLE, so the current count is the right one whenever state_n owns.
  always_comb begin
    grant = '0;
    sel_n = 1'b0;
    cnt_n = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      grant[i] = trigger && (winner == WID_W'(i));
      if (id_n == WID_W'(i)) begin
        sel_n = map_sel[i];
        cnt_n = line_cnt[i];
      end
    end
    row_n  = cnt_n[TILE_LOG2 +: ROW_W];
    addr_n = ADDR_W'(build_map_addr(32'(BASE_HI), sel_n, 32'(row_n),
                                    32'(col_n), ROW_W, COL_W));
  end

  always_ff @(posedge clk2) begin
    if (reset_video2) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk2) begin
    if (reset_video2) begin
      col      <= '0;
      win_id   <= '0;
      map_addr <= RESET_ADDR;
      fine_y   <= '0;
    end else begin
      col    <= col_n;
      win_id <= id_n;
      if (state_n != IDLE) begin
        map_addr <= addr_n;
        fine_y   <= cnt_n[TILE_LOG2-1:0];
      end
    end
  end

endmodule

// File: tb/tb_window_tile_fetcher.sv
// Self-checking bench for window_tile_fetcher with two windows, default
// geometry: map_addr = {2'b11, sel, row[4:0], col[4:0]}.
module tb_window_tile_fetcher;

  logic        clk2 = 1'b0;
  logic        reset_video2;
  logic        frame_start;
  logic        line_start;
  logic [7:0]  h;
  logic [7:0]  v;
  logic [1:0]  win_en;
  logic [15:0] win_x;
  logic [15:0] win_y;
  logic [1:0]  map_sel;
  logic        fetch_req;
  logic        win_start;
  logic        win_active;
  logic [0:0]  win_id;
  logic [12:0] map_addr;
  logic [2:0]  fine_y;

  int errors = 0;
  int checks = 0;

  always #5 clk2 = ~clk2;

  window_tile_fetcher #(
    .NUM_WIN (2)
  ) dut (
    .clk2         (clk2),
    .reset_video2 (reset_video2),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .h            (h),
    .v            (v),
    .win_en       (win_en),
    .win_x        (win_x),
    .win_y        (win_y),
    .map_sel      (map_sel),
    .fetch_req    (fetch_req),
    .win_start    (win_start),
    .win_active   (win_active),
    .win_id       (win_id),
    .map_addr     (map_addr),
    .fine_y       (fine_y)
  );

  typedef struct {
    logic       ls;
    logic       fr;
    logic [7:0] h;
    logic [7:0] v;
    logic [1:0] en;
    logic       e_start;
    logic       e_active;
    logic [12:0] e_addr;
    logic [2:0] e_fine;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic es, input logic ea);
    chk({tag, ".start"},  32'(win_start),  32'(es));
    chk({tag, ".active"}, 32'(win_active), 32'(ea));
  endtask

  task automatic chk_out(input string tag, input logic es, input logic ea,
                         input logic eid, input logic [12:0] eaddr,
                         input logic [2:0] efine);
    chk_st(tag, es, ea);
    chk({tag, ".id"},   32'(win_id),   32'(eid));
    chk({tag, ".addr"}, 32'(map_addr), 32'(eaddr));
    chk({tag, ".fine"}, 32'(fine_y),   32'(efine));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ls, fetch, h, v, en, start, active, addr, fine
    vecs[0]  = '{1'b0, 1'b0, 8'd0,  8'd16, 2'b01, 1'b0, 1'b0, 13'h1800, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'd7,  8'd16, 2'b01, 1'b1, 1'b1, 13'h1C00, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 8'd8,  8'd16, 2'b01, 1'b0, 1'b1, 13'h1C00, 3'd0};
    vecs[3]  = '{1'b0, 1'b1, 8'd9,  8'd16, 2'b01, 1'b0, 1'b1, 13'h1C01, 3'd0};
    vecs[4]  = '{1'b0, 1'b0, 8'd10, 8'd16, 2'b01, 1'b0, 1'b1, 13'h1C01, 3'd0};
    vecs[5]  = '{1'b1, 1'b0, 8'd0,  8'd17, 2'b01, 1'b0, 1'b0, 13'h1C01, 3'd0};
    vecs[6]  = '{1'b0, 1'b0, 8'd7,  8'd17, 2'b01, 1'b1, 1'b1, 13'h1C00, 3'd1};
    vecs[7]  = '{1'b1, 1'b0, 8'd0,  8'd18, 2'b01, 1'b0, 1'b0, 13'h1C00, 3'd1};
    vecs[8]  = '{1'b1, 1'b0, 8'd7,  8'd18, 2'b01, 1'b0, 1'b0, 13'h1C00, 3'd1};
    vecs[9]  = '{1'b0, 1'b0, 8'd8,  8'd18, 2'b01, 1'b0, 1'b0, 13'h1C00, 3'd1};
    vecs[10] = '{1'b1, 1'b0, 8'd0,  8'd19, 2'b01, 1'b0, 1'b0, 13'h1C00, 3'd1};
    vecs[11] = '{1'b0, 1'b0, 8'd7,  8'd19, 2'b01, 1'b1, 1'b1, 13'h1C00, 3'd2};
    vecs[12] = '{1'b0, 1'b1, 8'd8,  8'd19, 2'b01, 1'b0, 1'b1, 13'h1C01, 3'd2};

    reset_video2 = 1'b1;
    frame_start  = 1'b0;
    line_start   = 1'b0;
    fetch_req    = 1'b0;
    h            = 8'd0;
    v            = 8'd0;
    win_en       = 2'b01;
    win_x        = {8'd7, 8'd7};
    win_y        = {8'd16, 8'd16};
    map_sel      = 2'b01;
    step();
    step();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 13'h1800, 3'd0);
    reset_video2 = 1'b0;

    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk_st("frame0", 1'b0, 1'b0);

    // Basic start, next-line fine_y, trigger dropped under line_start
    for (int i = 0; i < 13; i++) begin
      line_start = vecs[i].ls;
      fetch_req  = vecs[i].fr;
      h          = vecs[i].h;
      v          = vecs[i].v;
      win_en     = vecs[i].en;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_active,
              1'b0, vecs[i].e_addr, vecs[i].e_fine);
    end
    line_start = 1'b0;
    fetch_req  = 1'b0;

    // Column wrap; fetch_req in the trigger cycle is ignored
    line_start = 1'b1; v = 8'd20; h = 8'd0;
    step();
    line_start = 1'b0;
    chk_st("wrap.ls", 1'b0, 1'b0);
    h = 8'd7; fetch_req = 1'b1;
    step();
    chk_out("wrap.trig", 1'b1, 1'b1, 1'b0, 13'h1C00, 3'd3);
    for (int k = 1; k <= 33; k++) begin
      fetch_req = 1'b1;
      h = 8'(8 + k);
      step();
      chk_out($sformatf("wrap%0d", k), 1'b0, 1'b1, 1'b0,
              13'h1C00 | 13'(k % 32), 3'd3);
    end
    fetch_req = 1'b0;

    // Abort and re-trigger on the same line
    line_start = 1'b1; v = 8'd21; h = 8'd0;
    step();
    line_start = 1'b0;
    h = 8'd7;
    step();
    chk_out("abort.trig", 1'b1, 1'b1, 1'b0, 13'h1C00, 3'd4);
    fetch_req = 1'b1; h = 8'd8;
    step();
    h = 8'd9;
    step();
    chk_out("abort.col2", 1'b0, 1'b1, 1'b0, 13'h1C02, 3'd4);
    fetch_req = 1'b0;
    win_en = 2'b00; h = 8'd20;
    step();
    chk_st("abort.drop", 1'b0, 1'b0);
    win_en = 2'b01; win_x[7:0] = 8'd50; h = 8'd50;
    step();
    chk_out("abort.retrig", 1'b1, 1'b1, 1'b0, 13'h1C00, 3'd4);
    win_x[7:0] = 8'd7; h = 8'd51;
    step();
    chk_st("abort.hold", 1'b0, 1'b1);
    line_start = 1'b1; v = 8'd22; h = 8'd0;
    step();
    line_start = 1'b0;
    h = 8'd7;
    step();
    chk_out("abort.once", 1'b1, 1'b1, 1'b0, 13'h1C00, 3'd5);

    // frame_start together with v == win_y leaves y_hit clear
    frame_start = 1'b1; v = 8'd16; h = 8'd0;
    step();
    frame_start = 1'b0;
    chk_st("fs.idle", 1'b0, 1'b0);
    line_start = 1'b1; v = 8'd17;
    step();
    line_start = 1'b0;
    h = 8'd7;
    step();
    chk_st("fs.notrig", 1'b0, 1'b0);
    step();
    chk_st("fs.notrig2", 1'b0, 1'b0);

    // Priority: both windows match, window 0 wins, window 1 keeps count 0
    frame_start = 1'b1; v = 8'd0; h = 8'd0; win_en = 2'b11;
    step();
    frame_start = 1'b0;
    v = 8'd16;
    step();
    h = 8'd7;
    step();
    chk_out("prio", 1'b1, 1'b1, 1'b0, 13'h1C00, 3'd0);
    line_start = 1'b1; v = 8'd17; h = 8'd0;
    step();
    line_start = 1'b0;
    win_en = 2'b10; h = 8'd7;
    step();
    chk_out("prio.ch1", 1'b1, 1'b1, 1'b1, 13'h1800, 3'd0);

    // Eight active lines advance the tile row
    frame_start = 1'b1; v = 8'd0; h = 8'd0; win_en = 2'b01;
    step();
    frame_start = 1'b0;
    chk_st("rows.fs", 1'b0, 1'b0);
    v = 8'd16;
    step();
    for (int l = 0; l < 8; l++) begin
      h = 8'd7;
      step();
      chk_out($sformatf("rows%0d", l), 1'b1, 1'b1, 1'b0, 13'h1C00, 3'(l));
      h = 8'd8;
      step();
      line_start = 1'b1; h = 8'd0; v = 8'(17 + l);
      step();
      line_start = 1'b0;
    end
    h = 8'd7;
    step();
    chk_out("row1", 1'b1, 1'b1, 1'b0, 13'h1C20, 3'd0);

    // Reset while owning the fetcher
    reset_video2 = 1'b1; h = 8'd8;
    step();
    chk_out("rst.mid", 1'b0, 1'b0, 1'b0, 13'h1800, 3'd0);
    reset_video2 = 1'b0; h = 8'd7;
    step();
    chk_st("rst.nohit", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
